// File: rtl/pio_gen.sv
// Parametrised Avalon-MM GPIO slave: per-bit direction, synchronised inputs with
// edge capture, maskable level interrupt and atomic set/clear of output bits.
module pio_gen #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter int unsigned           EDGE_TYPE   = 0,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_clr;
    logic             wr;

    assign wr      = chipselect && !write_n;
    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_in;
        end
    end

    always_comb begin
        edge_hit = sync_in & ~prev;
        if (EDGE_TYPE == 1) begin
            edge_hit = ~sync_in & prev;
        end else if (EDGE_TYPE == 2) begin
            edge_hit = sync_in ^ prev;
        end
    end

    always_comb begin
        edge_clr = '0;
        if (wr && address == ADDR_EDGE) begin
            edge_clr = writedata;
        end
    end

    // A new edge overrides a simultaneous write-one-to-clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~edge_clr) | edge_hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            dir      <= '0;
            irqmask  <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA: data_out <= writedata;
                ADDR_DIR:  dir      <= writedata;
                ADDR_MASK: irqmask  <= writedata;
                ADDR_SET:  data_out <= data_out | writedata;
                ADDR_CLR:  data_out <= data_out & ~writedata;
                default:   ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA: readdata = (sync_in & ~dir) | (data_out & dir);
                ADDR_DIR:  readdata = dir;
                ADDR_MASK: readdata = irqmask;
                ADDR_EDGE: readdata = edgecap;
                default:   readdata = '0;
            endcase
        end
    end

    assign out_port = data_out;
    assign out_en   = dir;
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_gen.sv
// Directed self-checking bench for pio_gen (WIDTH=8, rising capture, 2 sync stages);
// expectations are queued when stimulus is driven and popped when the DUT is sampled.
module tb_pio_gen;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_entry_t;

    logic       clk;
    logic       reset_n;
    logic [2:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic [7:0] out_en;
    logic       irq;

    sb_entry_t  sb[$];
    int         assertions;
    int         failures;

    pio_gen #(
        .WIDTH(8),
        .RESET_VALUE(8'h00),
        .EDGE_TYPE(0),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .out_port(out_port),
        .out_en(out_en),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expectPush(input string tag, input logic [7:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [7:0] observed);
        sb_entry_t e;
        assertions++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=<none>", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.exp);
            end
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic readCheck(input logic [2:0] addr, input logic [7:0] exp, input string tag);
        expectPush(tag, exp);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = addr;
        #1;
        checkOutput(readdata);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // Reset state
        expectPush("rst_out_port", 8'h00); checkOutput(out_port);
        expectPush("rst_out_en", 8'h00);   checkOutput(out_en);
        expectPush("rst_irq", 8'h00);      checkOutput({7'b0, irq});
        for (int a = 0; a < 8; a++) begin
            readCheck(3'(a), 8'h00, $sformatf("rst_read_addr%0d", a));
        end

        // Output path: plain write, atomic set and clear
        applyStimulus(3'd0, 8'hA5);
        expectPush("data_write", 8'hA5); checkOutput(out_port);
        applyStimulus(3'd4, 8'h0F);
        expectPush("set_bits", 8'hAF);   checkOutput(out_port);
        applyStimulus(3'd5, 8'h81);
        expectPush("clr_bits", 8'h2E);   checkOutput(out_port);
        readCheck(3'd4, 8'h00, "set_reads_zero");
        applyStimulus(3'd1, 8'hFF);
        expectPush("dir_out_en", 8'hFF); checkOutput(out_en);
        readCheck(3'd0, 8'h2E, "data_all_outputs");
        readCheck(3'd1, 8'hFF, "dir_readback");
        applyStimulus(3'd6, 8'h55);
        expectPush("addr6_ignored", 8'h2E); checkOutput(out_port);

        // Mixed direction read
        applyStimulus(3'd1, 8'hF0);
        applyStimulus(3'd0, 8'hA0);
        in_port = 8'h05;
        idle(4);
        readCheck(3'd0, 8'hA5, "data_mixed_dir");
        readCheck(3'd3, 8'h05, "edge_on_input_bits");
        applyStimulus(3'd3, 8'hFF);
        readCheck(3'd3, 8'h00, "edge_w1c_all");

        // Rising capture and interrupt
        in_port = 8'h04;
        idle(4);
        readCheck(3'd3, 8'h00, "falling_not_captured");
        applyStimulus(3'd2, 8'h01);
        readCheck(3'd2, 8'h01, "mask_readback");
        in_port = 8'h05;
        idle(2);
        expectPush("irq_before_capture", 8'h00); checkOutput({7'b0, irq});
        idle(1);
        expectPush("irq_after_capture", 8'h01);  checkOutput({7'b0, irq});
        readCheck(3'd3, 8'h01, "edge_bit0_captured");
        in_port = 8'h04;
        idle(4);
        readCheck(3'd3, 8'h01, "edge_bit0_held");
        applyStimulus(3'd3, 8'h01);
        expectPush("irq_after_w1c", 8'h00); checkOutput({7'b0, irq});

        // Edge capture and W1C of the same bit in the same cycle
        in_port = 8'h0C;
        idle(2);
        applyStimulus(3'd3, 8'h08);
        readCheck(3'd3, 8'h08, "edge_set_wins");
        expectPush("irq_unmasked_bit3", 8'h00); checkOutput({7'b0, irq});
        applyStimulus(3'd3, 8'h08);
        readCheck(3'd3, 8'h00, "edge_bit3_cleared");

        // Masking and asynchronous reset
        in_port = 8'h0F;
        idle(4);
        readCheck(3'd3, 8'h03, "edge_bits01");
        applyStimulus(3'd2, 8'h00);
        expectPush("irq_mask0", 8'h00); checkOutput({7'b0, irq});
        applyStimulus(3'd2, 8'h02);
        expectPush("irq_mask2", 8'h01); checkOutput({7'b0, irq});
        in_port = 8'h8F;
        idle(1);
        #2;
        reset_n = 1'b0;
        #1;
        expectPush("async_rst_irq", 8'h00);      checkOutput({7'b0, irq});
        expectPush("async_rst_out_port", 8'h00); checkOutput(out_port);
        expectPush("async_rst_out_en", 8'h00);   checkOutput(out_en);
        @(negedge clk);
        readCheck(3'd3, 8'h00, "async_rst_edgecap");
        readCheck(3'd2, 8'h00, "async_rst_mask");
        reset_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
